regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
32-entry register file with a per-register busy scoreboard. It is the consumer of the 5-to-32 write-enable decoder.
- Dispatch claims a destination register, which marks it busy.
- Writeback writes the data and clears busy.
- Two read ports return the operand and a ready flag to the issue stage.
- It sits between dispatch/issue and writeback in the mwe core.

Parameters:
DATA_W, 64, register width in bits
BYPASS, 1, 1 = same-cycle writeback forwarded to read ports; 0 = read returns stored value only

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  writeback valid
wr_addr  in  5  writeback destination register
wr_data  in  DATA_W  writeback value
claim_en  in  1  dispatch claims a destination
claim_addr  in  5  register being claimed
rd_addr_a  in  5  read port A address
rd_addr_b  in  5  read port B address
rd_data_a  out  DATA_W  port A operand
rd_data_b  out  DATA_W  port B operand
rd_ready_a  out  1  port A operand valid (not awaiting writeback)
rd_ready_b  out  1  port B operand valid
busy_vec  out  32  current busy bit per register (bit n = reg n)

Behaviour:
- Interface (already decided): one clock, clk. reset is synchronous and active-high.
- Reset: on any rising edge with reset=1:
  - all 32 registers become 0; busy_vec becomes 32'h0.
  - reset dominates wr_en and claim_en in that cycle, including mid-operation.
  - After reset, every rd_ready_* is 1 and every rd_data_* is 0.
- Write enable decode:
  - wr_addr is decoded into a one-hot 32-bit enable, gated by wr_en, through the enable decoder sub-module.
  - Only the selected register loads wr_data on the rising edge. Write latency is 1 cycle.
- Register 0:
  - Hardwired zero. Writes and claims to address 0 are ignored.
  - Reads of 0 return data 0, ready 1. busy_vec[0] is always 0.
- Busy set: claim_en=1 and claim_addr!=0 sets busy_vec[claim_addr] at the edge.
- Busy clear: wr_en=1 and wr_addr!=0 clears busy_vec[wr_addr] at the edge.
- Simultaneous claim and writeback:
  - Same register: claim wins (busy stays 1) and data is still written. The new producer is outstanding.
  - Different registers: both actions take effect independently.
- Claim of an already-busy register: busy stays 1, no error. Upstream stalls WAW hazards.
- Writeback to a non-busy register: data written, busy stays 0.
- Reads (combinational, 0-cycle latency, stored values):
  - rd_data_x = reg[rd_addr_x]
  - rd_ready_x = ~busy_vec[rd_addr_x]
- Bypass (BYPASS=1): if wr_en && wr_addr==rd_addr_x && wr_addr!=0, then rd_data_x = wr_data and rd_ready_x = 1. A same-cycle claim does not suppress this.
- BYPASS=0: the written value and cleared busy bit are visible the cycle after the edge.
- Both read ports may address the same register; they give identical results.
- busy_vec is a registered output, with no combinational path from inputs.

Decomposition:
- Shared package (mwe_pkg): NUM_REGS=32, REG_ADDR_W=5, typedef reg_addr_t, default DATA_W constant.
- Sub-module enable_decoder32:
  - Ports: en, sel[4:0], out[31:0].
  - Built from two 4-to-16 decoders selected by sel[4] and gated by en, at gate level as the codebase's existing decoders are.
  - Instantiated twice: once for writeback enables, once for claim enables.
- Storage and busy flops: flop arrays with per-entry enable muxes. Read ports: 32:1 muxes.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every rd_data=0, rd_ready=1, busy_vec=0.
- Claim r5, next cycle read r5 -> rd_ready_a=0, busy_vec=32'h20. Writeback r5=64'hDEAD_BEEF -> same-cycle bypass rd_data_a=64'hDEADBEEF and rd_ready_a=1; next cycle busy_vec=0.
- Claim r7 and writeback r7=64'h1234 in the same cycle -> next cycle busy_vec[7]=1 and stored r7=64'h1234. Repeat with claim r7, writeback r9 -> busy_vec[7]=1, busy_vec[9]=0.
- Write r0=64'hFFFF with claim_en on r0 -> rd_data=0, rd_ready=1, busy_vec[0]=0.
- Claim r3 and write r4=64'hAA, then assert reset with wr_en/claim_en active -> next cycle all registers 0, busy_vec=0.
- BYPASS=0 build: write r12=64'h55 and read r12 in the same cycle -> old value returned; the following cycle returns 64'h55.

Source files
------------

// File: rtl/mwe_pkg.sv
// Shared definitions for the mwe core register file slice.
//   NUM_REGS       : number of architectural registers
//   REG_ADDR_W     : register address width
//   reg_addr_t     : register address type
//   DATA_W_DEFAULT : default register width in bits
package mwe_pkg;
  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_W     = 5;
  localparam int DATA_W_DEFAULT = 64;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/enable_decoder32.sv
// 5-to-32 one-hot enable decoder.
// Two 4-to-16 decoders share the sel[3:0] minterms; sel[4] picks which
// half is enabled and en gates both halves.
// Ports:
//   en   in   1   global enable; out is all-zero when low
//   sel  in   5   index to decode
//   out  out  32  one-hot enable, out[sel] = en
module enable_decoder32 (
  input  logic        en,
  input  logic [4:0]  sel,
  output logic [31:0] out
);
  logic [3:0]  sel_n;
  logic [15:0] minterm;
  logic        en_lo;
  logic        en_hi;

  assign sel_n = ~sel[3:0];
  assign en_lo = en & ~sel[4];
  assign en_hi = en &  sel[4];

  for (genvar i = 0; i < 16; i++) begin : g_dec
    localparam logic [3:0] IDX = 4'(i);
    logic t3, t2, t1, t0;
    // Each minterm ANDs the true or complemented select bit per position.
    assign t3 = IDX[3] ? sel[3] : sel_n[3];
    assign t2 = IDX[2] ? sel[2] : sel_n[2];
    assign t1 = IDX[1] ? sel[1] : sel_n[1];
    assign t0 = IDX[0] ? sel[0] : sel_n[0];
    assign minterm[i] = t3 & t2 & t1 & t0;
    assign out[i]      = en_lo & minterm[i];
    assign out[16 + i] = en_hi & minterm[i];
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// 32-entry register file with per-register busy scoreboard.
// Dispatch claims a destination (sets busy); writeback stores data and
// clears busy. Two combinational read ports return operand + ready.
// Register 0 is hardwired zero and never busy.
//
// Strobe semantics: wr_en and claim_en are single-cycle valid strobes with
// no back-pressure (no ready). An action is taken on every rising edge
// where its strobe is high and reset is low; upstream is responsible for
// stalling WAW hazards.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data   writeback strobe, destination, value
//   claim_en/claim_addr     dispatch claim strobe, destination
//   rd_addr_a/rd_addr_b     read port addresses
//   rd_data_a/rd_data_b     read operands
//   rd_ready_a/rd_ready_b   operand not awaiting writeback
//   busy_vec                registered busy bit per register
module regfile_scoreboard
  import mwe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [4:0]        claim_addr,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_ready_a,
  output logic              rd_ready_b,
  output logic [31:0]       busy_vec
);
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] wr_dec;
  logic [NUM_REGS-1:0] claim_dec;
  logic                byp_a;
  logic                byp_b;

  enable_decoder32 u_wr_dec (
    .en  (wr_en),
    .sel (wr_addr),
    .out (wr_dec)
  );

  enable_decoder32 u_claim_dec (
    .en  (claim_en),
    .sel (claim_addr),
    .out (claim_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      // Entry 0 is held at zero so the read mux needs no special case.
      regs[0]   <= '0;
      busy_q[0] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_dec[i]) begin
          regs[i] <= wr_data;
        end
        // A claim in the same cycle as writeback wins: the new producer
        // is still outstanding.
        if (claim_dec[i]) begin
          busy_q[i] <= 1'b1;
        end else if (wr_dec[i]) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  assign byp_a = (BYPASS != 0) && wr_en && (wr_addr == rd_addr_a) && (wr_addr != 5'd0);
  assign byp_b = (BYPASS != 0) && wr_en && (wr_addr == rd_addr_b) && (wr_addr != 5'd0);

  always_comb begin
    rd_data_a  = regs[rd_addr_a];
    rd_ready_a = ~busy_q[rd_addr_a];
    if (byp_a) begin
      rd_data_a  = wr_data;
      rd_ready_a = 1'b1;
    end
  end

  always_comb begin
    rd_data_b  = regs[rd_addr_b];
    rd_ready_b = ~busy_q[rd_addr_b];
    if (byp_b) begin
      rd_data_b  = wr_data;
      rd_ready_b = 1'b1;
    end
  end

  assign busy_vec = busy_q;
endmodule
